// File: rtl/clock_divider_100mhz_to_1hz.sv
// Counter-based divider: produces a 50 % duty square wave at OUT_FREQ_HZ from CLK_FREQ_HZ,
// plus a one-cycle strobe on each rising transition. clk_out is data, not a clock.
module clock_divider_100mhz_to_1hz #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned OUT_FREQ_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out,
  output logic tick
);

  // Fall back to a harmless value for illegal configs so elaboration reaches the checks below.
  localparam int unsigned HALF_COUNT =
      (OUT_FREQ_HZ > 0 && CLK_FREQ_HZ >= 2 * OUT_FREQ_HZ) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 1;
  localparam int unsigned CNT_W = (HALF_COUNT > 1) ? $clog2(HALF_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_COUNT - 1);

  if (OUT_FREQ_HZ == 0) begin : g_err_out_freq
    $error("clock_divider_100mhz_to_1hz: OUT_FREQ_HZ must be greater than 0");
  end
  if (OUT_FREQ_HZ > 0 && CLK_FREQ_HZ < 2 * OUT_FREQ_HZ) begin : g_err_too_slow
    $error("clock_divider_100mhz_to_1hz: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
  end
  if (OUT_FREQ_HZ > 0 && (CLK_FREQ_HZ % (2 * OUT_FREQ_HZ)) != 0) begin : g_err_not_divisible
    $error("clock_divider_100mhz_to_1hz: CLK_FREQ_HZ must be divisible by 2*OUT_FREQ_HZ");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    wrap      = (count_q == CNT_MAX);
    count_d   = wrap ? '0 : count_q + CNT_W'(1);
    clk_out_d = wrap ? ~clk_out_q : clk_out_q;
    // Strobe only on the 0->1 toggle.
    tick_d    = wrap & ~clk_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_100mhz_to_1hz.sv
// Directed bench: default, HALF_COUNT=10 and HALF_COUNT=1 instances share clock and reset;
// expected outputs come from edge counts since reset release.
module tb_clock_divider_100mhz_to_1hz;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic d_out, d_tick;  // defaults, HALF_COUNT = 50_000_000
  logic s_out, s_tick;  // CLK_FREQ_HZ = 20, HALF_COUNT = 10
  logic t_out, t_tick;  // CLK_FREQ_HZ = 2,  HALF_COUNT = 1

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  clock_divider_100mhz_to_1hz u_dut_default (
    .clk     (clk),
    .rst     (rst),
    .clk_out (d_out),
    .tick    (d_tick)
  );

  clock_divider_100mhz_to_1hz #(
    .CLK_FREQ_HZ (20),
    .OUT_FREQ_HZ (1)
  ) u_dut_small (
    .clk     (clk),
    .rst     (rst),
    .clk_out (s_out),
    .tick    (s_tick)
  );

  clock_divider_100mhz_to_1hz #(
    .CLK_FREQ_HZ (2),
    .OUT_FREQ_HZ (1)
  ) u_dut_tiny (
    .clk     (clk),
    .rst     (rst),
    .clk_out (t_out),
    .tick    (t_tick)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected outputs after k clk edges since release, for half-period h.
  function automatic logic exp_out(input int k, input int h);
    return logic'((k / h) % 2);
  endfunction

  function automatic logic exp_tick(input int k, input int h);
    return (k % (2 * h)) == h;
  endfunction

  // One edge-aligned step: advance to edge k and compare all instances to the model.
  task automatic step_and_check(input int k);
    @(posedge clk);
    #1;
    check($sformatf("small_out[k=%0d]", k), {31'd0, s_out}, {31'd0, exp_out(k, 10)});
    check($sformatf("small_tick[k=%0d]", k), {31'd0, s_tick}, {31'd0, exp_tick(k, 10)});
    check($sformatf("tiny[k=%0d]", k), {30'd0, t_out, t_tick},
          {30'd0, exp_out(k, 1), exp_tick(k, 1)});
    check($sformatf("default[k=%0d]", k), {30'd0, d_out, d_tick}, 32'd0);
  endtask

  initial begin
    int ticks;
    int high_cycles;
    int first_rise;
    int first_fall;
    logic prev_out;

    // Reset hold: all outputs low for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", {26'd0, d_out, d_tick, s_out, s_tick, t_out, t_tick}, 32'd0);
    end

    @(negedge clk);
    rst = 1'b1;

    ticks       = 0;
    high_cycles = 0;
    first_rise  = -1;
    first_fall  = -1;
    prev_out    = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step_and_check(k);
      if (s_tick) ticks++;
      if (s_out) high_cycles++;
      if (s_out && !prev_out && first_rise < 0) first_rise = k;
      if (!s_out && prev_out && first_fall < 0) first_fall = k;
      if (s_tick) check("tick_on_rise", {31'd0, s_out && !prev_out}, 32'd1);
      prev_out = s_out;
    end
    check("first_rise_edge", first_rise, 32'd10);
    check("first_fall_edge", first_fall, 32'd20);
    check("tick_pulses_100", ticks, 32'd5);
    check("high_cycles_100", high_cycles, 32'd50);

    // Advance into the high phase 110..119 and stop at its 7th cycle (edge 116).
    for (int k = 101; k <= 116; k++) step_and_check(k);
    check("pre_reset_high", {31'd0, s_out}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_small", {30'd0, s_out, s_tick}, 32'd0);
    check("async_reset_tiny", {30'd0, t_out, t_tick}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {26'd0, d_out, d_tick, s_out, s_tick, t_out, t_tick}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    first_rise = -1;
    prev_out   = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step_and_check(k);
      if (s_out && !prev_out && first_rise < 0) first_rise = k;
      prev_out = s_out;
    end
    check("rise_after_reset", first_rise, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
